pwm_decoder: RTL and testbench

PWM_DECODER -- requirements
Module: pwm_decoder

---
 rtl/pwm_decoder_pkg.sv | 20 ++
 rtl/pwm_decoder_sync_edge.sv | 41 ++++
 rtl/pwm_decoder.sv | 176 +++++++++++++++++
 tb/tb_pwm_decoder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_decoder_pkg.sv
// Shared types and sizing for the PWM duty-level decoder.
// State encoding, default frame/level widths and counter width helper.
package pwm_decoder_pkg;

    localparam int PERIOD_DEF  = 256;
    localparam int LEVEL_W_DEF = 7;

    function automatic int cnt_w(input int period);
        return $clog2(period);
    endfunction

    localparam int CNT_W_DEF = cnt_w(PERIOD_DEF);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_MEASURE
    } state_e;

endpackage

// File: rtl/pwm_decoder_sync_edge.sv
// Two-flop synchroniser plus previous-sample register for pwm_in.
// Sample and rising-edge flag leave through one output register.
module pwm_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sample,
    output logic rise
);

    logic [2:0] sh_q;
    logic [2:0] sh_d;
    logic       sample_q;
    logic       sample_d;
    logic       rise_q;
    logic       rise_d;

    // shift the input through sync1, sync2 and prev; rise is sync & ~prev
    always_comb begin
        sh_d     = {sh_q[1:0], din};
        sample_d = sh_q[1];
        rise_d   = sh_q[1] & ~sh_q[2];
    end

    // all synchroniser state clears while reset is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q     <= '0;
            sample_q <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            sh_q     <= sh_d;
            sample_q <= sample_d;
            rise_q   <= rise_d;
        end
    end

    assign sample = sample_q;
    assign rise   = rise_q;

endmodule

// File: rtl/pwm_decoder.sv
// Recovers the duty level of a frame-aligned PWM stream.
// Locks on a rising edge, counts high cycles per frame, strobes result.
module pwm_decoder
    import pwm_decoder_pkg::*;
#(
    parameter int PERIOD  = PERIOD_DEF,
    parameter int LEVEL_W = LEVEL_W_DEF
) (
    input  logic               CLK100MHZ,
    input  logic               CPU_RESETN,
    input  logic               pwm_in,
    input  logic               enable,
    output logic [LEVEL_W-1:0] level,
    output logic               level_valid,
    output logic               locked,
    output logic               timeout
);

    localparam int CW    = cnt_w(PERIOD);
    localparam int TW    = CW + 1;
    localparam int LMAXI = (1 << LEVEL_W) - 1;

    localparam logic [CW-1:0]      POS_LAST = CW'(PERIOD - 1);
    localparam logic [TW-1:0]      TO_LAST  = TW'(2 * PERIOD - 1);
    localparam logic [LEVEL_W-1:0] LVL_TOP  = '1;

    function automatic logic [LEVEL_W-1:0] sat(input logic [CW:0] v);
        if (int'(v) > LMAXI) return LVL_TOP;
        return LEVEL_W'(v);
    endfunction

    logic [1:0] rst_sync_q;
    logic [1:0] rst_sync_d;
    logic       rst_n;
    logic       sample;
    logic       rise;

    state_e             state_q, state_d;
    logic [CW-1:0]      pos_q, pos_d;
    logic [CW:0]        high_q, high_d;
    logic [TW-1:0]      to_q, to_d;
    logic               mis_q, mis_d;
    logic               misp_q, misp_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               valid_q, valid_d;
    logic               locked_q, locked_d;
    logic               timeout_q, timeout_d;

    // reset asserts at once, releases two clocks after CPU_RESETN rises
    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    // reset release synchroniser
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) rst_sync_q <= '0;
        else             rst_sync_q <= rst_sync_d;
    end

    assign rst_n = rst_sync_q[1];

    pwm_sync_edge u_sync (
        .clk    (CLK100MHZ),
        .rst_n  (rst_n),
        .din    (pwm_in),
        .sample (sample),
        .rise   (rise)
    );

    // next-state logic for the search / measure controller
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        high_d    = high_q;
        to_d      = to_q;
        mis_d     = mis_q;
        misp_d    = misp_q;
        level_d   = level_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        if (rise) timeout_d = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
            pos_d   = '0;
            high_d  = '0;
            to_d    = '0;
            mis_d   = 1'b0;
            misp_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_SEARCH;
                    to_d    = '0;
                end
                S_SEARCH: begin
                    if (rise) begin
                        state_d = S_MEASURE;
                        pos_d   = '0;
                        high_d  = (CW+1)'(1);
                        to_d    = '0;
                        mis_d   = 1'b0;
                        misp_d  = 1'b0;
                    end else if (to_q == TO_LAST) begin
                        timeout_d = 1'b1;
                        valid_d   = 1'b1;
                        level_d   = sample ? LVL_TOP : '0;
                        to_d      = '0;
                    end else begin
                        to_d = to_q + TW'(1);
                    end
                end
                S_MEASURE: begin
                    if (pos_q == POS_LAST) begin
                        // this cycle's sample is position 0 of the next window
                        pos_d  = '0;
                        high_d = {{CW{1'b0}}, sample};
                        mis_d  = 1'b0;
                        if (mis_q && misp_q) begin
                            state_d = S_SEARCH;
                            to_d    = '0;
                            misp_d  = 1'b0;
                            high_d  = '0;
                        end else begin
                            valid_d = 1'b1;
                            level_d = sat(high_q);
                            misp_d  = mis_q;
                            if (high_q == '0) begin
                                state_d = S_SEARCH;
                                to_d    = '0;
                                misp_d  = 1'b0;
                                high_d  = '0;
                            end
                        end
                    end else begin
                        pos_d  = pos_q + CW'(1);
                        high_d = high_q + {{CW{1'b0}}, sample};
                        if (rise) mis_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        locked_d = (state_d == S_MEASURE);
    end

    // controller state and registered outputs
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pos_q     <= '0;
            high_q    <= '0;
            to_q      <= '0;
            mis_q     <= 1'b0;
            misp_q    <= 1'b0;
            level_q   <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            high_q    <= high_d;
            to_q      <= to_d;
            mis_q     <= mis_d;
            misp_q    <= misp_d;
            level_q   <= level_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign level       = level_q;
    assign level_valid = valid_q;
    assign locked      = locked_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder with a frame-based PWM generator.
// Expected levels and strobe spacings are hand-computed constants.
module tb_pwm_decoder;

    logic       CLK100MHZ = 1'b0;
    logic       CPU_RESETN;
    logic       pwm_in;
    logic       enable;
    logic [6:0] level;
    logic       level_valid;
    logic       locked;
    logic       timeout;

    int  checks = 0;
    int  errors = 0;
    int  vcount = 0;
    int  dbl = 0;
    bit  prev_v = 1'b0;
    bit  gen_on = 1'b0;
    int  fpos = 0;
    int  d = 0;
    int  lvl = 0;
    int  lvl_next = 0;
    int  shift_pend = 0;

    pwm_decoder dut (
        .CLK100MHZ   (CLK100MHZ),
        .CPU_RESETN  (CPU_RESETN),
        .pwm_in      (pwm_in),
        .enable      (enable),
        .level       (level),
        .level_valid (level_valid),
        .locked      (locked),
        .timeout     (timeout)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // one clock: sample outputs, then drive the next PWM bit
    task automatic tick();
        @(posedge CLK100MHZ);
        #1;
        if (level_valid) begin
            vcount++;
            if (prev_v) dbl++;
        end
        prev_v = level_valid;
        if (gen_on) begin
            fpos++;
            if (fpos == 256 + d) begin
                fpos = 0;
                lvl  = lvl_next;
                if (shift_pend > 0) begin
                    d = 37;
                    shift_pend--;
                end else begin
                    d = 0;
                end
            end
            pwm_in = (fpos >= d) && (fpos - d < lvl);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_valid(input int budget, output int n, output bit found);
        n = 0;
        found = 1'b0;
        while (!found && n < budget) begin
            tick();
            n++;
            if (level_valid) found = 1'b1;
        end
    endtask

    task automatic start_gen(input int l);
        lvl        = l;
        lvl_next   = l;
        fpos       = 0;
        d          = 0;
        shift_pend = 0;
        gen_on     = 1'b1;
        pwm_in     = (l > 0);
    endtask

    initial begin
        int  n;
        bit  f;
        int  v0;
        int  k;

        CPU_RESETN = 1'b0;
        enable     = 1'b1;
        pwm_in     = 1'b0;
        ticks(4);
        chk("rst_level", int'(level), 0);
        chk("rst_valid", int'(level_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_timeout", int'(timeout), 0);

        // pwm held low: search timeout strobes level 0
        CPU_RESETN = 1'b1;
        wait_valid(700, n, f);
        chk("low_to_lat", n, 515);
        chk("low_to_level", int'(level), 0);
        chk("low_to_flag", int'(timeout), 1);
        chk("low_to_locked", int'(locked), 0);

        // level 64 frames: strobe PERIOD+4 after the opening edge
        start_gen(64);
        wait_valid(600, n, f);
        chk("l64_lat", n, 260);
        chk("l64_level", int'(level), 64);
        chk("l64_locked", int'(locked), 1);
        chk("l64_to_clr", int'(timeout), 0);
        wait_valid(600, n, f);
        chk("l64_gap", n, 256);
        chk("l64_level2", int'(level), 64);

        // level steps 64 -> 100 -> 3 -> 0 at frame boundaries
        lvl_next = 100;
        wait_valid(600, n, f);
        chk("s64_gap", n, 256);
        chk("s64_level", int'(level), 64);
        wait_valid(600, n, f);
        chk("s100_gap", n, 256);
        chk("s100_level", int'(level), 100);
        lvl_next = 3;
        wait_valid(600, n, f);
        chk("s100b_gap", n, 256);
        chk("s100b_level", int'(level), 100);
        wait_valid(600, n, f);
        chk("s3_gap", n, 256);
        chk("s3_level", int'(level), 3);
        lvl_next = 0;
        wait_valid(600, n, f);
        chk("s3b_level", int'(level), 3);
        wait_valid(600, n, f);
        chk("s0_gap", n, 256);
        chk("s0_level", int'(level), 0);
        chk("s0_unlock", int'(locked), 0);
        wait_valid(700, n, f);
        chk("s0_to_gap", n, 512);
        chk("s0_to_flag", int'(timeout), 1);

        // relock on level 50, timeout clears on the rising edge
        lvl_next = 50;
        wait_valid(800, n, f);
        chk("l50_found", int'(f), 1);
        chk("l50_level", int'(level), 50);
        chk("l50_locked", int'(locked), 1);
        chk("l50_to_clr", int'(timeout), 0);

        // two successive 37-cycle phase shifts
        for (int i = 0; i < 300 && fpos != 128; i++) tick();
        shift_pend = 2;
        v0 = vcount;
        k = 0;
        while (locked && k < 1200) begin
            tick();
            k++;
        end
        chk("sh_unlock", int'(locked), 0);
        chk("sh_strobes", vcount - v0, 2);
        chk("sh_level", int'(level), 50);
        wait_valid(1000, n, f);
        chk("sh_found", int'(f), 1);
        chk("sh_relock_level", int'(level), 50);
        chk("sh_relock", int'(locked), 1);

        // enable low: idle, level held
        enable = 1'b0;
        ticks(2);
        chk("en_locked", int'(locked), 0);
        chk("en_level", int'(level), 50);

        // reset mid-window at position 120 with level 90
        lvl_next = 90;
        ticks(300);
        enable = 1'b1;
        wait_valid(800, n, f);
        chk("l90_level", int'(level), 90);
        chk("l90_locked", int'(locked), 1);
        ticks(120);
        CPU_RESETN = 1'b0;
        #1;
        chk("mr_level", int'(level), 0);
        chk("mr_valid", int'(level_valid), 0);
        chk("mr_locked", int'(locked), 0);
        chk("mr_timeout", int'(timeout), 0);
        ticks(4);
        CPU_RESETN = 1'b1;
        wait_valid(1000, n, f);
        chk("mr_found", int'(f), 1);
        chk("mr_no_partial", int'(n >= 264), 1);
        chk("mr_level90", int'(level), 90);
        chk("mr_relock", int'(locked), 1);

        // pwm held high: timeout strobes saturated maximum
        gen_on     = 1'b0;
        pwm_in     = 1'b1;
        enable     = 1'b0;
        CPU_RESETN = 1'b0;
        ticks(3);
        CPU_RESETN = 1'b1;
        ticks(10);
        enable = 1'b1;
        wait_valid(700, n, f);
        chk("hi_to_lat", n, 513);
        chk("hi_to_level", int'(level), 127);
        chk("hi_to_flag", int'(timeout), 1);
        chk("hi_to_locked", int'(locked), 0);
        start_gen(40);
        ticks(300);
        chk("hi_to_clr", int'(timeout), 0);
        chk("hi_relock", int'(locked), 1);

        chk("no_back2back", dbl, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
